// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_pkg
// Brief   : Shared command encodings, FSM states and sign helpers for the
//           iterative multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Matches the mult_div field driven by the control unit; 2'b11 is a no-op.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_MULT = 2'b01,
        OP_DIV  = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // One extra bit so the magnitude of the most negative value is exact.
    function automatic logic [DEFAULT_WIDTH:0] abs_w(input logic [DEFAULT_WIDTH-1:0] x);
        return x[DEFAULT_WIDTH-1] ? ({1'b0, ~x} + 1'b1) : {1'b0, x};
    endfunction

    function automatic logic [DEFAULT_WIDTH-1:0] neg_w(input logic [DEFAULT_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_if
// Brief   : Command/result bundle between the control unit and the
//           multiply/divide unit.
// Revision: 1.0 - initial release
// ============================================================================
interface mult_div_if #(
    parameter int WIDTH = mult_div_pkg::DEFAULT_WIDTH
);
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (
        output op, a, b,
        input  hi, lo, busy, done, div0
    );

    modport slave (
        input  op, a, b,
        output hi, lo, busy, done, div0
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mult_div_unit
// Brief   : Signed MULT/DIV over WIDTH shift-add / restoring shift-subtract
//           iterations; results held in HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic      clock,
    input  logic      reset,
    mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           r_state;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [WIDTH:0]   r_opnd;   // multiplicand (MULT) or divisor (DIV) magnitude
    logic [WIDTH:0]   r_acc;    // upper product half / partial remainder
    logic [WIDTH-1:0] r_mq;     // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;

    logic             w_is_mult;
    logic             w_is_div;
    logic [WIDTH:0]   w_abs_a;
    logic [WIDTH:0]   w_abs_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_fits;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_is_mult = (bus.op == OP_MULT);
        w_is_div  = (bus.op == OP_DIV);
        w_abs_a   = abs_w(bus.a);
        w_abs_b   = abs_w(bus.b);
        w_add     = r_acc + (r_mq[0] ? r_opnd : '0);
        w_shift   = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
        w_sub     = w_shift - r_opnd;
        w_fits    = (w_shift >= r_opnd);
        w_prod    = {r_acc[WIDTH-1:0], r_mq};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_is_div && (bus.b == '0)) begin
                        r_done <= 1'b1;
                        r_div0 <= 1'b1;
                    end else if (w_is_mult || w_is_div) begin
                        r_is_div  <= w_is_div;
                        r_neg_res <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_neg_rem <= bus.a[WIDTH-1];
                        r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
                        r_mq      <= w_is_div ? w_abs_a[WIDTH-1:0] : w_abs_b[WIDTH-1:0];
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_fits ? w_sub : w_shift;
                        r_mq  <= {r_mq[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc <= {1'b0, w_add[WIDTH:1]};
                        r_mq  <= {w_add[0], r_mq[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    // Quotient follows the operand signs, remainder the dividend's.
                    if (r_is_div) begin
                        r_lo <= r_neg_res ? neg_w(r_mq) : r_mq;
                        r_hi <= r_neg_rem ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
                    end else begin
                        {r_hi, r_lo} <= r_neg_res ? (~w_prod + 1'b1) : w_prod;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_div_unit
// Brief   : Directed self-checking bench for mult_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   lat;
    int   seen;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a command for exactly one edge, then release op.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clock);
        @(negedge clock);
        bus.op = 2'b00;
    endtask

    // Counts edges from the command edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        bus.op = 2'b00;
        bus.a  = '0;
        bus.b  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_hi",   {32'h0, bus.hi}, 64'h0);
        check("rst_lo",   {32'h0, bus.lo}, 64'h0);
        check("rst_flags", {61'h0, bus.busy, bus.done, bus.div0}, 64'h0);
        reset = 1'b0;

        // 7 * -3
        issue(2'b01, 32'd7, 32'hFFFF_FFFD);
        check("m1_busy", {63'h0, bus.busy}, 64'h1);
        wait_done(lat);
        check("m1_lat", 64'(lat), 64'd33);
        check("m1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("m1_busy_done", {63'h0, bus.busy}, 64'h0);
        @(negedge clock);
        check("m1_pulse", {63'h0, bus.done}, 64'h0);

        // most negative squared
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        check("m2_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        // -7 / 2
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("d1_lat", 64'(lat), 64'd33);
        check("d1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // overflow corner
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("d2_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // 100 / -7 : q=-14, r=2
        issue(2'b10, 32'd100, 32'hFFFF_FFF9);
        wait_done(lat);
        check("d3_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFF2);

        // preload then divide by zero
        issue(2'b01, 32'd3, 32'd5);
        wait_done(lat);
        check("m3_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        issue(2'b10, 32'd9, 32'd0);
        check("dz_flags", {61'h0, bus.busy, bus.done, bus.div0}, 64'h3);
        check("dz_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
        @(negedge clock);
        check("dz_after", {61'h0, bus.busy, bus.done, bus.div0}, 64'h0);

        // op 11 is a no-op
        issue(2'b11, 32'd4, 32'd4);
        check("op11_idle", {62'h0, bus.busy, bus.done}, 64'h0);

        // op changes during RUN are ignored
        issue(2'b01, 32'd100, 32'd100);
        repeat (4) @(negedge clock);
        bus.op = 2'b10;
        bus.a  = 32'd1;
        bus.b  = 32'd0;
        repeat (3) @(negedge clock);
        bus.op = 2'b00;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        check("ign_div0", {63'h0, bus.div0}, 64'h0);
        check("ign_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_2710);

        // reset aborts a running MULT
        issue(2'b01, 32'd2, 32'd2);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        check("abort_flags", {62'h0, bus.busy, bus.done}, 64'h0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);

        // op held: back-to-back MULTs 34 cycles apart
        bus.op = 2'b01;
        bus.a  = 32'd2;
        bus.b  = 32'd3;
        @(posedge clock);
        @(negedge clock);
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_lo1", {bus.hi, bus.lo}, 64'd6);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (bus.done !== 1'b1 && lat < 60);
        bus.op = 2'b00;
        check("b2b_gap", 64'(lat), 64'd34);
        check("b2b_lo2", {bus.hi, bus.lo}, 64'd6);
        repeat (2) @(negedge clock);
        check("b2b_stop", {62'h0, bus.busy, bus.done}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
